mult_booth: RTL and testbench

Iterative 32x32 signed multiplier for the execute stage, next to the ALU shifter. Operands come in from the decode/register-read stage. The block runs radix-2 Booth recoding with one add/subtract and one 1-bit arithmetic right shift per cycle. It returns the low 32 bits of the product, plus an overflow flag, to the writeback mux.

---
 rtl/mult_booth_if.sv | 23 ++
 rtl/mult_booth.sv | 114 +++++++++++
 tb/tb_mult_booth.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mult_booth_if.sv
// mult_booth_if: request/result bundle for the iterative Booth multiplier.
//   start, operand_a, operand_b : request side (master drives)
//   busy, result_valid, result, overflow : status/result side (slave drives)
// Modports: master = requester (decode/testbench), slave = mult_booth.
interface mult_booth_if;
  logic        start;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic        overflow;

  modport master (
    output start, operand_a, operand_b,
    input  busy, result_valid, result, overflow
  );

  modport slave (
    input  start, operand_a, operand_b,
    output busy, result_valid, result, overflow
  );
endinterface

// File: rtl/mult_booth.sv
// mult_booth: iterative 32x32 signed multiplier, radix-2 Booth, one
// add/subtract plus one arithmetic right shift per cycle. 32 RUN cycles,
// then a single DONE cycle carrying result_valid.
// Ports:
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : mult_booth_if.slave (start/operands in; busy, result_valid,
//             result = low 32 bits of a*b, overflow out)
// Build option: define MULT_OVF_EN to build the overflow register and the
// P[63:31] sign-agreement compare; otherwise overflow is tied to 0.
module mult_booth (
  input  logic         clock,
  input  logic         reset_n,
  mult_booth_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [32:0] acc;         // A, 33 bits so A - sext(0x80000000) cannot overflow
  logic [32:0] acc_sum;
  logic [32:0] acc_next;
  logic [31:0] mcand;       // M
  logic [31:0] mplier;      // Q
  logic [31:0] mplier_next;
  logic        q_m1;
  logic        q_m1_next;
  logic [4:0]  count;
  logic [31:0] result_reg;
  logic        accept;
  logic        last_iter;

  assign accept    = bus.start && ((state == IDLE) || (state == DONE));
  assign last_iter = (state == RUN) && (count == 5'd31);

  // One Booth step: conditional add/sub, then shift {A,Q,q-1} right by one
  // with A's sign bit replicated.
  always_comb begin
    acc_sum = acc;
    case ({mplier[0], q_m1})
      2'b01:   acc_sum = acc + {mcand[31], mcand};
      2'b10:   acc_sum = acc - {mcand[31], mcand};
      default: acc_sum = acc;
    endcase
    acc_next    = {acc_sum[32], acc_sum[32:1]};
    mplier_next = {acc_sum[0], mplier[31:1]};
    q_m1_next   = mplier[0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      q_m1       <= 1'b0;
      count      <= '0;
      result_reg <= '0;
    end else begin
      if (accept) begin
        acc    <= '0;
        mcand  <= bus.operand_a;
        mplier <= bus.operand_b;
        q_m1   <= 1'b0;
        count  <= '0;
      end else if (state == RUN) begin
        acc    <= acc_next;
        mplier <= mplier_next;
        q_m1   <= q_m1_next;
        count  <= count + 5'd1;
      end
      // P[31:0] is Q after the final shift, captured on the DONE entry edge.
      if (last_iter) result_reg <= mplier_next;
    end
  end

`ifdef MULT_OVF_EN
  logic ovf_reg;

  // Overflow when P[63:32] (= A[31:0] after the final shift) is not a
  // pure sign extension of P[31].
  always_ff @(posedge clock) begin
    if (!reset_n)       ovf_reg <= 1'b0;
    else if (last_iter) ovf_reg <= (acc_next[31:0] != {32{mplier_next[31]}});
  end

  assign bus.overflow = ovf_reg;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.busy         = (state == RUN);
  assign bus.result_valid = (state == DONE);
  assign bus.result       = result_reg;

endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth: self-checking bench for mult_booth. Expected products are
// computed with a 64-bit signed multiply when a request is accepted, queued
// with the cycle they are due, and compared when result_valid appears.
module tb_mult_booth;

  logic clock;
  logic reset_n;
  logic [31:0] cyc;

  mult_booth_if bus ();

  mult_booth dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = '0;
  always @(posedge clock) cyc <= cyc + 32'd1;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic [31:0] due;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
  endtask

  // Called #1 after the accepting edge; valid cycle t+33 sees cyc = now+32.
  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    exp_t e;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    e.res = p[31:0];
`ifdef MULT_OVF_EN
    e.ovf = (p[63:32] != {32{p[31]}});
`else
    e.ovf = 1'b0;
`endif
    e.due = cyc + 32'd32;
    exp_q.push_back(e);
  endtask

  // Scoreboard side.
  always @(negedge clock) begin
    if (bus.result_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result",  {32'd0, bus.result}, {32'd0, e.res});
        check("overflow", {63'd0, bus.overflow}, {63'd0, e.ovf});
        check("latency", {32'd0, cyc}, {32'd0, e.due});
      end
    end
  end

  // Drive a request starting from the next falling edge; start stays high
  // after acceptance when keep is set.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit keep);
    @(negedge clock);
    bus.start     = 1'b1;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clock);
    #1;
    push_exp(a, b);
    if (!keep) bus.start = 1'b0;
  endtask

  // Observe the 32 RUN cycles and the DONE cycle that follows an accept.
  task automatic watch_run(input string tag);
    int unsigned misses;
    misses = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) misses++;
    end
    check({tag, "_busy32"}, 64'(misses), 64'd0);
    @(negedge clock);
    check({tag, "_done_busy"}, {63'd0, bus.busy}, 64'd0);
    check({tag, "_done_valid"}, {63'd0, bus.result_valid}, 64'd1);
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clock);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned misses;
    bus.start     = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    reset_n       = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_busy",   {63'd0, bus.busy}, 64'd0);
    check("rst_valid",  {63'd0, bus.result_valid}, 64'd0);
    check("rst_result", {32'd0, bus.result}, 64'd0);
    check("rst_ovf",    {63'd0, bus.overflow}, 64'd0);

    // Directed operand patterns.
    issue(32'd7, 32'd6, 1'b0);                 watch_run("pos");
    issue(32'hFFFF_FFFD, 32'd5, 1'b0);         watch_run("mixed");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0); watch_run("minneg");
    issue(32'h0001_0000, 32'h0001_0000, 1'b0); watch_run("big");
    issue(32'd0, 32'h1234_5678, 1'b0);         watch_run("zero");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); watch_run("negone");
    issue(32'h8000_0000, 32'h8000_0000, 1'b0); watch_run("minsq");
    issue(32'h7FFF_FFFF, 32'd1, 1'b0);         watch_run("maxpos");
    idle_cycles(2);

    // Start while busy: ignored, exactly one result.
    issue(32'd7, 32'd6, 1'b0);
    misses = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clock);
      if (bus.busy !== 1'b1) misses++;
      if (i == 5) begin
        bus.start = 1'b1; bus.operand_a = 32'd2; bus.operand_b = 32'd2;
      end
      if (i == 6) bus.start = 1'b0;
    end
    check("ignore_busy32", 64'(misses), 64'd0);
    @(negedge clock);
    check("ignore_valid", {63'd0, bus.result_valid}, 64'd1);
    idle_cycles(40);
    check("ignore_idle", {63'd0, bus.busy}, 64'd0);

    // Reset in the middle of an operation.
    issue(32'd123, 32'd456, 1'b0);
    idle_cycles(10);
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check("midrst_busy",   {63'd0, bus.busy}, 64'd0);
    check("midrst_result", {32'd0, bus.result}, 64'd0);
    check("midrst_ovf",    {63'd0, bus.overflow}, 64'd0);
    idle_cycles(40);
    issue(32'd11, 32'hFFFF_FFF9, 1'b0); watch_run("after_rst");

    // Back-to-back: second start accepted in the DONE cycle.
    issue(32'd3, 32'd4, 1'b1);
    watch_run("b2b_first");
    bus.operand_a = 32'hFFFF_FFFE;
    bus.operand_b = 32'hFFFF_FFFE;
    @(posedge clock);
    #1;
    push_exp(32'hFFFF_FFFE, 32'hFFFF_FFFE);
    bus.start = 1'b0;
    watch_run("b2b_second");

    // Random operands.
    for (int i = 0; i < 8; i++) begin
      issue($urandom, $urandom, 1'b0);
      watch_run("rand");
    end

    idle_cycles(3);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
